// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 codes, access sizes
// and small decode helpers used by lsu_mod and lsu_align.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Access size is funct3[1:0] for both loads and stores.
    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } lsu_size_e;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] FUNC3_LB  = 3'b000;
    localparam logic [2:0] FUNC3_LH  = 3'b001;
    localparam logic [2:0] FUNC3_LW  = 3'b010;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_LHU = 3'b101;
    localparam logic [2:0] FUNC3_SB  = 3'b000;
    localparam logic [2:0] FUNC3_SH  = 3'b001;
    localparam logic [2:0] FUNC3_SW  = 3'b010;

    function automatic logic legal_funct3(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == FUNC3_SB) || (f3 == FUNC3_SH) || (f3 == FUNC3_SW);
        end
        return (f3 == FUNC3_LB) || (f3 == FUNC3_LH) || (f3 == FUNC3_LW) ||
               (f3 == FUNC3_LBU) || (f3 == FUNC3_LHU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (lsu_size_e'(f3[1:0]))
            SIZE_H:  return off[0];
            SIZE_W:  return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and lane-replicated write data for requests,
// and lane shift plus sign/zero extension for returning load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shift;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = st_data_i;
        case (lsu_size_e'(req_size_i))
            SIZE_B: begin
                be_o    = 4'b0001 << req_off_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            SIZE_H: begin
                be_o    = 4'b0011 << {req_off_i[1], 1'b0};
                wdata_o = {2{st_data_i[15:0]}};
            end
            SIZE_W: begin
                be_o    = 4'b1111;
                wdata_o = st_data_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = st_data_i;
            end
        endcase
    end

    // funct3[2] selects zero extension (LBU/LHU).
    always_comb begin
        ld_shift  = rdata_i;
        ld_data_o = '0;
        case (lsu_size_e'(ld_funct3_i[1:0]))
            SIZE_B: begin
                ld_shift  = rdata_i >> {ld_off_i, 3'b000};
                ld_data_o = ld_funct3_i[2] ? {24'd0, ld_shift[7:0]}
                                           : {{24{ld_shift[7]}}, ld_shift[7:0]};
            end
            SIZE_H: begin
                ld_shift  = rdata_i >> {ld_off_i[1], 4'b0000};
                ld_data_o = ld_funct3_i[2] ? {16'd0, ld_shift[15:0]}
                                           : {{16{ld_shift[15]}}, ld_shift[15:0]};
            end
            SIZE_W: begin
                ld_data_o = ld_shift;
            end
            default: begin
                ld_data_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mod.sv
// Load/store unit: one request/grant/response transaction per accepted op, with timeout.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned halfword/word accesses.
module lsu_mod
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] inst,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        busy,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       off_q;
    logic [2:0]       funct3_q;
    logic             we_q;

    logic        req_ready_q, busy_q, resp_valid_q, resp_err_q;
    logic        dmem_req_q, dmem_we_q;
    logic [3:0]  dmem_be_q;
    logic [31:0] resp_data_q, dmem_addr_q, dmem_wdata_q;

    logic        is_load, is_store, misalign_trap, op_ok;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, ld_data_d;
    logic        unused_inst;

    assign is_load     = inst[6:0] == OPCODE_LOAD;
    assign is_store    = inst[6:0] == OPCODE_STORE;
    assign unused_inst = ^{inst[31:15], inst[11:7]};

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_trap = misaligned(inst[14:12], addr[1:0]);
`else
    assign misalign_trap = 1'b0;
`endif

    assign op_ok = (is_load || is_store) && legal_funct3(is_store, inst[14:12]) && !misalign_trap;

    lsu_align u_align (
        .req_size_i  (inst[13:12]),
        .req_off_i   (addr[1:0]),
        .st_data_i   (st_data),
        .be_o        (be_d),
        .wdata_o     (wdata_d),
        .ld_funct3_i (funct3_q),
        .ld_off_i    (off_q),
        .rdata_i     (dmem_rdata),
        .ld_data_o   (ld_data_d)
    );

    // Counter spans REQ+WAIT; a grant or rvalid in the final allowed cycle still completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_be_q    <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        off_q       <= addr[1:0];
                        funct3_q    <= inst[14:12];
                        we_q        <= is_store;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (op_ok) begin
                            state_q      <= ST_REQ;
                            cnt_q        <= '0;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= is_store;
                            dmem_be_q    <= be_d;
                            dmem_addr_q  <= {addr[31:2], 2'b00};
                            dmem_wdata_q <= is_store ? wdata_d : '0;
                        end else begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        if (we_q) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= dmem_err;
                            resp_data_q  <= '0;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q      <= ST_RESP;
                        dmem_req_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= dmem_err;
                        resp_data_q  <= ld_data_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_data_q  <= '0;
                    busy_q       <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    dmem_req_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_lsu_mod.sv
// Directed bench for lsu_mod: a vector table of zero-wait transactions plus hand-written
// sequences for delayed grant, timeout, reset mid-transaction and misaligned words.
module tb_lsu_mod;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int         NUM_VEC  = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    int    checkCount = 0;
    int    passCount  = 0;
    string curTag     = "reset";

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] stData;
        logic [31:0] rdata;
        logic        isStore;
        logic        legal;
        logic        memErr;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecs [NUM_VEC];

    lsu_mod #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .inst        (inst),
        .addr        (addr),
        .st_data     (st_data),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .busy        (busy),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_be     (dmem_be),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .dmem_err    (dmem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mkInst(input logic isStore, input logic [2:0] f3);
        return {17'd0, f3, 5'd0, isStore ? OP_STORE : OP_LOAD};
    endfunction

    function automatic vec_t mkVec(input logic isStore, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] sd,
                                   input logic [31:0] rd, input logic legal,
                                   input logic memErr, input logic [31:0] expAddr,
                                   input logic [3:0] expBe, input logic [31:0] expWdata,
                                   input logic [31:0] expData, input logic expErr);
        vec_t v;
        v.inst     = mkInst(isStore, f3);
        v.addr     = a;
        v.stData   = sd;
        v.rdata    = rd;
        v.isStore  = isStore;
        v.legal    = legal;
        v.memErr   = memErr;
        v.expAddr  = expAddr;
        v.expBe    = expBe;
        v.expWdata = expWdata;
        v.expData  = expData;
        v.expErr   = expErr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s.%s actual=0x%08h expected=0x%08h",
                      curTag, name, actual, expected);
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s.%s actual=%b expected=%b", curTag, name, actual, expected);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic offerReq(input logic [31:0] i, input logic [31:0] a, input logic [31:0] sd);
        int waitCnt = 0;
        while (!req_ready && waitCnt < 20) begin
            stepCycle();
            waitCnt++;
        end
        checkBit("readyBeforeReq", req_ready, 1'b1);
        req_valid = 1'b1;
        inst      = i;
        addr      = a;
        st_data   = sd;
        stepCycle();
        req_valid = 1'b0;
        inst      = '0;
        addr      = '0;
        st_data   = '0;
    endtask

    // Zero-wait memory: gnt in first REQ cycle, rvalid the cycle after.
    task automatic applyStimulus(input vec_t v);
        offerReq(v.inst, v.addr, v.stData);
        if (v.legal) begin
            checkBit("reqAsserted", dmem_req, 1'b1);
            checkOutput("dmemAddr", dmem_addr, v.expAddr);
            checkOutput("dmemBe", {28'd0, dmem_be}, {28'd0, v.expBe});
            checkBit("dmemWe", dmem_we, v.isStore);
            if (v.isStore) checkOutput("dmemWdata", dmem_wdata, v.expWdata);
            checkBit("noEarlyResp1", resp_valid, 1'b0);
            dmem_gnt = 1'b1;
            dmem_err = v.isStore ? v.memErr : 1'b0;
            stepCycle();
            dmem_gnt = 1'b0;
            dmem_err = 1'b0;
            if (!v.isStore) begin
                checkBit("reqDropInWait", dmem_req, 1'b0);
                checkBit("noEarlyResp2", resp_valid, 1'b0);
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.rdata;
                dmem_err    = v.memErr;
                stepCycle();
                dmem_rvalid = 1'b0;
                dmem_rdata  = '0;
                dmem_err    = 1'b0;
            end
        end else begin
            checkBit("noDmemReq", dmem_req, 1'b0);
        end
        checkBit("respValid", resp_valid, 1'b1);
        checkOutput("respData", resp_data, v.expData);
        checkBit("respErr", resp_err, v.expErr);
        checkBit("busyInResp", busy, 1'b1);
        stepCycle();
        checkBit("respPulseEnd", resp_valid, 1'b0);
        checkBit("readyAfterResp", req_ready, 1'b1);
        checkBit("busyAfterResp", busy, 1'b0);
    endtask

    initial begin
        int pulses;

        // isStore f3 addr stData rdata legal memErr expAddr expBe expWdata expData expErr
        vecs[0]  = mkVec(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, 0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        vecs[1]  = mkVec(1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 0, 32'h100, 4'h8, 32'hA5A5A5A5, 32'h0, 0);
        vecs[2]  = mkVec(1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 1, 0, 32'h100, 4'hC, 32'hBEEFBEEF, 32'h0, 0);
        vecs[3]  = mkVec(1, 3'b000, 32'h201, 32'h0000007E, 32'h0, 1, 0, 32'h200, 4'h2, 32'h7E7E7E7E, 32'h0, 0);
        vecs[4]  = mkVec(0, 3'b000, 32'h102, 32'h0, 32'h12345678, 1, 0, 32'h100, 4'h4, 32'h0, 32'h00000034, 0);
        vecs[5]  = mkVec(0, 3'b000, 32'h102, 32'h0, 32'h00F40000, 1, 0, 32'h100, 4'h4, 32'h0, 32'hFFFFFFF4, 0);
        vecs[6]  = mkVec(0, 3'b100, 32'h102, 32'h0, 32'h00F40000, 1, 0, 32'h100, 4'h4, 32'h0, 32'h000000F4, 0);
        vecs[7]  = mkVec(0, 3'b101, 32'h200, 32'h0, 32'h1234ABCD, 1, 0, 32'h200, 4'h3, 32'h0, 32'h0000ABCD, 0);
        vecs[8]  = mkVec(0, 3'b001, 32'h002, 32'h0, 32'h80010000, 1, 0, 32'h000, 4'hC, 32'h0, 32'hFFFF8001, 0);
        vecs[9]  = mkVec(0, 3'b010, 32'h204, 32'h0, 32'hCAFEF00D, 1, 0, 32'h204, 4'hF, 32'h0, 32'hCAFEF00D, 0);
        vecs[10] = mkVec(1, 3'b010, 32'h108, 32'h00000055, 32'h0, 1, 1, 32'h108, 4'hF, 32'h00000055, 32'h0, 1);
        vecs[11] = mkVec(0, 3'b011, 32'h010, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        vecs[12] = mkVec(1, 3'b100, 32'h010, 32'h12345678, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        vecs[13] = mkVec(0, 3'b000, 32'h103, 32'h0, 32'h7F000000, 1, 0, 32'h100, 4'h8, 32'h0, 32'h0000007F, 0);

        rst         = 1'b1;
        req_valid   = 1'b0;
        inst        = '0;
        addr        = '0;
        st_data     = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        dmem_err    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        stepCycle();

        curTag = "reset";
        checkBit("reqReady", req_ready, 1'b1);
        checkBit("busy", busy, 1'b0);
        checkBit("dmemReq", dmem_req, 1'b0);
        checkBit("respValid", resp_valid, 1'b0);
        checkBit("respErr", resp_err, 1'b0);
        checkOutput("respData", resp_data, 32'h0);
        checkBit("dmemWe", dmem_we, 1'b0);
        checkOutput("dmemBe", {28'd0, dmem_be}, 32'h0);
        checkOutput("dmemAddr", dmem_addr, 32'h0);
        checkOutput("dmemWdata", dmem_wdata, 32'h0);

        for (int i = 0; i < NUM_VEC; i++) begin
            curTag = $sformatf("v%0d", i);
            applyStimulus(vecs[i]);
        end

        // LH with grant delayed three cycles and rvalid two cycles after grant.
        curTag = "slowLh";
        offerReq(mkInst(0, 3'b001), 32'h2, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            checkBit("reqHeld", dmem_req, 1'b1);
            checkOutput("addrStable", dmem_addr, 32'h0);
            checkOutput("beStable", {28'd0, dmem_be}, 32'h0000000C);
            checkBit("busyHeld", busy, 1'b1);
            checkBit("noResp", resp_valid, 1'b0);
            if (k == 4) dmem_gnt = 1'b1;
            stepCycle();
        end
        dmem_gnt = 1'b0;
        checkBit("reqDropped", dmem_req, 1'b0);
        checkBit("busyWait1", busy, 1'b1);
        checkBit("noRespWait1", resp_valid, 1'b0);
        stepCycle();
        checkBit("busyWait2", busy, 1'b1);
        checkBit("noRespWait2", resp_valid, 1'b0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hC0DE0000;
        stepCycle();
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        checkOutput("respData", resp_data, 32'hFFFFC0DE);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            if (resp_valid) pulses++;
            if (k < 2) stepCycle();
        end
        checkOutput("pulseCount", pulses, 32'd1);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFFFFFF;
        stepCycle();
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        checkBit("strayRvalidIgnored", resp_valid, 1'b0);
        checkBit("strayRvalidIdle", busy, 1'b0);

        // No grant: abort after 8 REQ cycles, then a late grant must be ignored.
        curTag = "timeout";
        offerReq(mkInst(1, 3'b010), 32'h300, 32'h11223344);
        for (int k = 1; k <= 8; k++) begin
            checkBit("reqHeld", dmem_req, 1'b1);
            checkBit("noResp", resp_valid, 1'b0);
            stepCycle();
        end
        checkBit("respValid", resp_valid, 1'b1);
        checkBit("respErr", resp_err, 1'b1);
        checkOutput("respData", resp_data, 32'h0);
        checkBit("reqDropped", dmem_req, 1'b0);
        dmem_gnt = 1'b1;
        stepCycle();
        checkBit("lateGnt1", resp_valid, 1'b0);
        checkBit("idleAfter", busy, 1'b0);
        checkBit("readyAfter", req_ready, 1'b1);
        stepCycle();
        dmem_gnt = 1'b0;
        checkBit("lateGnt2", resp_valid, 1'b0);
        checkBit("lateGntNoReq", dmem_req, 1'b0);
        curTag = "afterTimeout";
        applyStimulus(vecs[0]);

        // Reset while REQ drives dmem_req: it must drop without a clock edge.
        curTag = "rstReq";
        offerReq(mkInst(0, 3'b010), 32'h400, 32'h0);
        checkBit("reqBefore", dmem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkBit("reqAsync", dmem_req, 1'b0);
        checkBit("busyAsync", busy, 1'b0);
        checkBit("respAsync", resp_valid, 1'b0);
        rst = 1'b0;
        stepCycle();
        checkBit("readyAfterRst", req_ready, 1'b1);

        curTag = "rstWait";
        offerReq(mkInst(0, 3'b010), 32'h404, 32'h0);
        dmem_gnt = 1'b1;
        stepCycle();
        dmem_gnt = 1'b0;
        checkBit("busyInWait", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkBit("busyAsync", busy, 1'b0);
        checkBit("reqAsync", dmem_req, 1'b0);
        checkBit("respAsync", resp_valid, 1'b0);
        #1 rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12345678;
        stepCycle();
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        checkBit("readyAfterRst", req_ready, 1'b1);
        checkBit("orphanRvalid", resp_valid, 1'b0);
        curTag = "afterRst";
        applyStimulus(vecs[5]);

        curTag = "misalignLw";
        offerReq(mkInst(0, 3'b010), 32'h101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checkBit("noDmemReq", dmem_req, 1'b0);
        checkBit("respValid", resp_valid, 1'b1);
        checkBit("respErr", resp_err, 1'b1);
        checkOutput("respData", resp_data, 32'h0);
        stepCycle();
`else
        checkBit("reqAsserted", dmem_req, 1'b1);
        checkOutput("dmemAddr", dmem_addr, 32'h100);
        checkOutput("dmemBe", {28'd0, dmem_be}, 32'h0000000F);
        dmem_gnt = 1'b1;
        stepCycle();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h87654321;
        stepCycle();
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        checkBit("respValid", resp_valid, 1'b1);
        checkBit("respErr", resp_err, 1'b0);
        checkOutput("respData", resp_data, 32'h87654321);
        stepCycle();
`endif
        checkBit("idleAtEnd", busy, 1'b0);
        checkBit("readyAtEnd", req_ready, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
